// File: rtl/multi_cycle_controller.sv
// ---------------------------------------------------------------------------
// multi_cycle_controller
//
// Sequencing FSM for the multi-cycle MIPS-subset datapath. Every instruction
// walks FETCH -> DECODE -> EXEC -> MEM -> WB and skips the states it does not
// need. A wait counter watches the instruction and data memory handshakes.
// If a memory stays not-ready for TIMEOUT_CYCLES consecutive cycles, the core
// parks in HALT until reset.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   op, func     IR[31:26] / IR[5:0], valid from DECODE onward
//   zero         ALU zero flag, used by beq in EXEC
//   imem_ready   instruction word available this cycle
//   dmem_ready   data access completes this cycle
//   PCWrite      PC load enable; PCSrc selects the PC source
//   IRWrite      IR load enable
//   MemRead      data memory read strobe; MemWrite is the write strobe
//   RegWrite     register file write enable
//   RegDst       destination register select; MemtoReg selects write-back data
//   ALUsrc       ALU operand B select; sign selects immediate sign extension
//   ALUControl   ALU operation select
//   state        current FSM state, for debug
//   instr_done   one-cycle pulse on the final cycle of each instruction
//   illegal      one-cycle pulse in DECODE for an unrecognised encoding
//   halted       sticky flag, set on a memory wait timeout
// ---------------------------------------------------------------------------
module multi_cycle_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       zero,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic       IRWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       ALUsrc,
   output logic       sign,
   output logic [2:0] ALUControl,
   output logic [2:0] state,
   output logic       instr_done,
   output logic       illegal,
   output logic       halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      K_ADDU, K_SUBU, K_OR, K_ORI, K_LUI, K_LW, K_SW,
      K_BEQ, K_J, K_JAL, K_JR, K_NOP, K_ILL
   } kind_t;

   // The halt decision is made on the last not-ready cycle. At that point
   // the counter holds TIMEOUT_CYCLES-1 earlier misses.
   localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

   state_t     cur_state, nxt_state;
   logic [7:0] wcnt, nxt_wcnt;
   logic       nxt_halted;
   kind_t      kind;
   logic       wait_expired;
   logic       is_rtype;

   assign state        = cur_state;
   assign wait_expired = (wcnt == WAIT_LIMIT);
   assign is_rtype     = (kind == K_ADDU) || (kind == K_SUBU) || (kind == K_OR);

   // Instruction classification. func is only meaningful for op 000000.
   always_comb begin
      kind = K_ILL;
      case (op)
         6'b000000: begin
            case (func)
               6'b100001: kind = K_ADDU;
               6'b100011: kind = K_SUBU;
               6'b100101: kind = K_OR;
               6'b001000: kind = K_JR;
               6'b000000: kind = K_NOP;
               default:   kind = K_ILL;
            endcase
         end
         6'b001101: kind = K_ORI;
         6'b001111: kind = K_LUI;
         6'b100011: kind = K_LW;
         6'b101011: kind = K_SW;
         6'b000100: kind = K_BEQ;
         6'b000010: kind = K_J;
         6'b000011: kind = K_JAL;
         default:   kind = K_ILL;
      endcase
   end

   // State register.
   // NOTE: the asynchronous reset sits in the sensitivity list so the FSM
   // clears without a clock. Every state update uses non-blocking
   // assignments, so all flops sample the pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_state <= S_FETCH;
         wcnt      <= 8'd0;
         halted    <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         wcnt      <= nxt_wcnt;
         halted    <= nxt_halted;
      end
   end

   // Next-state logic. A ready input takes precedence over an expiring
   // counter, so a response on the final allowed cycle still completes.
   always_comb begin
      nxt_state  = cur_state;
      nxt_wcnt   = wcnt;
      nxt_halted = halted;
      case (cur_state)
         S_FETCH: begin
            if (imem_ready) begin
               nxt_state = S_DECODE;
               nxt_wcnt  = 8'd0;
            end else if (wait_expired) begin
               nxt_state  = S_HALT;
               nxt_halted = 1'b1;
            end else begin
               nxt_wcnt = wcnt + 8'd1;
            end
         end
         S_DECODE: begin
            case (kind)
               K_J, K_JAL, K_JR, K_NOP, K_ILL: nxt_state = S_FETCH;
               default:                        nxt_state = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (kind)
               K_BEQ:      nxt_state = S_FETCH;
               K_LW, K_SW: nxt_state = S_MEM;
               default:    nxt_state = S_WB;
            endcase
         end
         S_MEM: begin
            if (dmem_ready) begin
               nxt_state = (kind == K_LW) ? S_WB : S_FETCH;
               nxt_wcnt  = 8'd0;
            end else if (wait_expired) begin
               nxt_state  = S_HALT;
               nxt_halted = 1'b1;
            end else begin
               nxt_wcnt = wcnt + 8'd1;
            end
         end
         S_WB:    nxt_state = S_FETCH;
         S_HALT:  nxt_state = S_HALT;
         default: nxt_state = S_FETCH;
      endcase
   end

   // Output decode. Outputs are gated off while reset is held low. During
   // reset the FSM already sits in FETCH, so an asserted imem_ready would
   // otherwise leak IRWrite/PCWrite.
   always_comb begin
      // NOTE: every output gets a default before the case. No path can then
      // leave an output unassigned, so no latches are inferred.
      PCWrite    = 1'b0;
      PCSrc      = 2'b00;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 2'b00;
      MemtoReg   = 2'b00;
      ALUsrc     = 1'b0;
      sign       = 1'b0;
      ALUControl = 3'b000;
      instr_done = 1'b0;
      illegal    = 1'b0;
      if (reset) begin
         case (cur_state)
            S_FETCH: begin
               IRWrite = imem_ready;
               PCWrite = imem_ready;
            end
            S_DECODE: begin
               case (kind)
                  K_J: begin
                     PCWrite    = 1'b1;
                     PCSrc      = 2'b10;
                     instr_done = 1'b1;
                  end
                  K_JAL: begin
                     PCWrite    = 1'b1;
                     PCSrc      = 2'b10;
                     RegWrite   = 1'b1;
                     RegDst     = 2'b10;
                     MemtoReg   = 2'b10;
                     instr_done = 1'b1;
                  end
                  K_JR: begin
                     PCWrite    = 1'b1;
                     PCSrc      = 2'b11;
                     instr_done = 1'b1;
                  end
                  K_NOP: instr_done = 1'b1;
                  K_ILL: begin
                     instr_done = 1'b1;
                     illegal    = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_EXEC: begin
               case (kind)
                  K_SUBU, K_BEQ: ALUControl = 3'b001;
                  K_OR, K_ORI:   ALUControl = 3'b011;
                  K_LUI:         ALUControl = 3'b100;
                  default:       ALUControl = 3'b000;
               endcase
               ALUsrc = (kind == K_ORI) || (kind == K_LUI) || (kind == K_LW) || (kind == K_SW);
               sign   = (kind == K_LW) || (kind == K_SW) || (kind == K_BEQ);
               if (kind == K_BEQ) begin
                  PCWrite    = zero;
                  PCSrc      = 2'b01;
                  instr_done = 1'b1;
               end
            end
            S_MEM: begin
               MemRead    = (kind == K_LW);
               MemWrite   = (kind == K_SW);
               instr_done = (kind == K_SW) && dmem_ready;
            end
            S_WB: begin
               RegWrite   = 1'b1;
               RegDst     = is_rtype ? 2'b01 : 2'b00;
               MemtoReg   = (kind == K_LW) ? 2'b01 : 2'b00;
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
